// File: rtl/am2900_pkg.sv
// Shared constants for the Am29xx microprogram sequencer family.
// Source-select codes and the decoded stack-operation type.
package am2900_pkg;

  localparam logic [1:0] SEL_UPC = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_D   = 2'b11;

  typedef enum logic [1:0] {
    STK_HOLD = 2'b00,
    STK_POP  = 2'b01,
    STK_PUSH = 2'b10
  } stk_op_e;

  // FE_N gates the stack; PUP picks direction only while enabled.
  function automatic stk_op_e stk_decode(input logic fe_n, input logic pup);
    stk_op_e op;
    if (fe_n) begin
      op = STK_HOLD;
    end else if (pup) begin
      op = STK_PUSH;
    end else begin
      op = STK_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/am29xx_lifo.sv
// Wrapping return-address stack: SP names the top word, count saturates at 0..DEPTH.
// AM29XX_STACK_ERR_EN adds a sticky overflow/underflow flag.
module am29xx_lifo
  import am2900_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
`ifdef AM29XX_STACK_ERR_EN
  output logic         err,
`endif
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] SP_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [W-1:0]  file_r [DEPTH];
  logic [AW-1:0] sp_r;
  logic [CW-1:0] count_r;

  // Stack pointer, occupancy and word storage; full/empty never block the pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        file_r[i] <= '0;
      end
      sp_r    <= '0;
      count_r <= '0;
    end else if (push) begin
      file_r[sp_r + SP_ONE] <= din;
      sp_r    <= sp_r + SP_ONE;
      count_r <= (count_r == CNT_MAX) ? count_r : count_r + CNT_ONE;
    end else if (pop) begin
      sp_r    <= sp_r - SP_ONE;
      count_r <= (count_r == '0) ? count_r : count_r - CNT_ONE;
    end
  end

  assign top   = file_r[sp_r];
  assign full  = (count_r == CNT_MAX);
  assign empty = (count_r == '0);

`ifdef AM29XX_STACK_ERR_EN
  logic err_r;

  // Sticky misuse flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | (push & full) | (pop & empty);
    end
  end

  assign err = err_r;
`endif

endmodule

// File: rtl/am29xx_sequencer.sv
// W-bit Am2909-style microprogram sequencer: source mux, OR/zero override, incrementer,
// uPC, address register and return stack. AM29XX_STACK_ERR_EN adds the ERR output.
module am29xx_sequencer
  import am2900_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         CP,
  input  logic         RST,
  input  logic [1:0]   S,
  input  logic [W-1:0] D,
  input  logic [W-1:0] R,
  input  logic         RE_N,
  input  logic         FE_N,
  input  logic         PUP,
  input  logic [W-1:0] OR,
  input  logic         ZERO_N,
  input  logic         CN,
  input  logic         OE_N,
  output logic [W-1:0] Y,
  output logic         COUT,
  output logic         FULL,
`ifdef AM29XX_STACK_ERR_EN
  output logic         ERR,
`endif
  output logic         EMPTY
);

  logic [W-1:0] upc_r;
  logic [W-1:0] ar_r;
  logic [W-1:0] top_s;
  logic [W-1:0] mux_s;
  logic [W-1:0] yi_s;
  logic [W-1:0] inc_s;
  logic         cout_s;
  stk_op_e      op_s;

  assign op_s = stk_decode(FE_N, PUP);

  // Address source selection.
  always_comb begin
    mux_s = upc_r;
    case (S)
      SEL_UPC: mux_s = upc_r;
      SEL_AR:  mux_s = ar_r;
      SEL_STK: mux_s = top_s;
      SEL_D:   mux_s = D;
      default: mux_s = upc_r;
    endcase
  end

  // The incrementer sees the internal address, so OE_N never disturbs sequencing.
  assign yi_s            = ZERO_N ? (mux_s | OR) : '0;
  assign {cout_s, inc_s} = {1'b0, yi_s} + {{W{1'b0}}, CN};

  // uPC follows the incrementer every cycle; AR loads on RE_N low.
  always_ff @(posedge CP or posedge RST) begin
    if (RST) begin
      upc_r <= '0;
      ar_r  <= '0;
    end else begin
      upc_r <= inc_s;
      ar_r  <= RE_N ? ar_r : R;
    end
  end

  am29xx_lifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (CP),
    .rst   (RST),
    .push  (op_s == STK_PUSH),
    .pop   (op_s == STK_POP),
    .din   (upc_r),
    .top   (top_s),
    .full  (FULL),
`ifdef AM29XX_STACK_ERR_EN
    .err   (ERR),
`endif
    .empty (EMPTY)
  );

  assign Y    = OE_N ? {W{1'bz}} : yi_s;
  assign COUT = cout_s;

endmodule

// File: tb/tb_am29xx_sequencer.sv
// Scoreboard bench for am29xx_sequencer: a W=4 instance for sequencing/stack/AR/OE/reset
// and a W=8 instance for carry, OR override and zero forcing.
module tb_am29xx_sequencer;

  typedef struct {
    string      name;
    int         id;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       cp = 1'b0;
  logic       rst;
  logic       re_n, fe_n, pup;
  logic [1:0] s4, s8;
  logic [3:0] d4, r4, or4;
  logic [7:0] d8, r8, or8;
  logic       zero_n4, cn4, oe_n4, zero_n8, cn8, oe_n8;
  wire  [3:0] y4;
  wire  [7:0] y8;
  logic       cout4, full4, empty4, err4;
  logic       cout8, full8, empty8, err8;

  // Released Y bits read as 1 so the high-Z state is observable.
  pullup (y4[0]);
  pullup (y4[1]);
  pullup (y4[2]);
  pullup (y4[3]);

  always #5 cp = ~cp;

  am29xx_sequencer #(.W(4), .DEPTH(4)) dut4 (
    .CP(cp), .RST(rst), .S(s4), .D(d4), .R(r4), .RE_N(re_n), .FE_N(fe_n), .PUP(pup),
    .OR(or4), .ZERO_N(zero_n4), .CN(cn4), .OE_N(oe_n4), .Y(y4), .COUT(cout4),
    .FULL(full4),
`ifdef AM29XX_STACK_ERR_EN
    .ERR(err4),
`endif
    .EMPTY(empty4)
  );

  am29xx_sequencer #(.W(8), .DEPTH(4)) dut8 (
    .CP(cp), .RST(rst), .S(s8), .D(d8), .R(r8), .RE_N(re_n), .FE_N(fe_n), .PUP(pup),
    .OR(or8), .ZERO_N(zero_n8), .CN(cn8), .OE_N(oe_n8), .Y(y8), .COUT(cout8),
    .FULL(full8),
`ifdef AM29XX_STACK_ERR_EN
    .ERR(err8),
`endif
    .EMPTY(empty8)
  );

`ifndef AM29XX_STACK_ERR_EN
  assign err4 = 1'b0;
  assign err8 = 1'b0;
`endif

  task automatic chk(input string n, input int id, input logic [7:0] v);
    exp_t e;
    e.name = n;
    e.id   = id;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge cp);
    #1;
  endtask

  // Monitor: on each falling edge, compare every pending expectation with the live outputs.
  always @(negedge cp) begin
    exp_t       e;
    logic [7:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.id)
        0:       act = {4'h0, y4};
        1:       act = {7'h00, cout4};
        2:       act = {7'h00, full4};
        3:       act = {7'h00, empty4};
        4:       act = {7'h00, err4};
        5:       act = y8;
        6:       act = {7'h00, cout8};
        default: act = 8'hxx;
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; re_n = 1'b1; fe_n = 1'b1; pup = 1'b0;
    s4 = 2'b00; d4 = 4'h0; r4 = 4'h0; or4 = 4'h0; zero_n4 = 1'b1; cn4 = 1'b1; oe_n4 = 1'b0;
    s8 = 2'b11; d8 = 8'hFF; r8 = 8'h00; or8 = 8'h00; zero_n8 = 1'b1; cn8 = 1'b1; oe_n8 = 1'b0;
    @(posedge cp);
    #1;
    rst = 1'b0;

    // Reset state, then count; W=8 carry/override in parallel
    chk("rst_y", 0, 8'h00); chk("rst_empty", 3, 8'h01); chk("rst_full", 2, 8'h00);
    chk("rst_cout", 1, 8'h00);
`ifdef AM29XX_STACK_ERR_EN
    chk("rst_err", 4, 8'h00);
`endif
    chk("w8_ff_y", 5, 8'hFF); chk("w8_ff_cout", 6, 8'h01);
    step();
    chk("inc1", 0, 8'h01);
    s8 = 2'b00; chk("w8_wrap", 5, 8'h00); chk("w8_cout0", 6, 8'h00);
    step();
    chk("inc2", 0, 8'h02);
    s8 = 2'b11; d8 = 8'h40; or8 = 8'h01; chk("w8_or", 5, 8'h41);
    step();
    cn4 = 1'b0; chk("inc3", 0, 8'h03);
    zero_n8 = 1'b0; chk("w8_zero", 5, 8'h00); chk("w8_zero_cout", 6, 8'h00);
    step();

    // Call and return
    cn4 = 1'b1; s4 = 2'b11; d4 = 4'h8; fe_n = 1'b0; pup = 1'b1; chk("call_y", 0, 8'h08);
    step();
    s4 = 2'b10; pup = 1'b0; chk("ret_top", 0, 8'h03); chk("ret_nonempty", 3, 8'h00);
    step();
    fe_n = 1'b1; s4 = 2'b00; chk("ret_upc", 0, 8'h04); chk("ret_empty", 3, 8'h01);
    step();

    // Overflow: pushes of 1..5, then pops
    s4 = 2'b11; d4 = 4'h0; chk("jmp0", 0, 8'h00);
    step();
    s4 = 2'b00; fe_n = 1'b0; pup = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("push_y", 0, 8'(i));
      if (i == 5) chk("full_before5", 2, 8'h01);
      step();
    end
    fe_n = 1'b1; s4 = 2'b10; chk("ovf_top", 0, 8'h05); chk("ovf_full", 2, 8'h01);
`ifdef AM29XX_STACK_ERR_EN
    chk("ovf_err", 4, 8'h01);
`endif
    step();
    fe_n = 1'b0; pup = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("pop_y", 0, 8'(5 - i));
      step();
    end
    chk("pop_empty_stale", 0, 8'h05); chk("pop_empty_flag", 3, 8'h01);
    step();
    fe_n = 1'b1; chk("wrap_stale", 0, 8'h04); chk("still_empty", 3, 8'h01);
    step();

    // Jump and address register
    s4 = 2'b11; d4 = 4'hA; chk("jmp_y", 0, 8'h0A);
    step();
    s4 = 2'b00; r4 = 4'h5; re_n = 1'b0; chk("jmp_upc", 0, 8'h0B);
    step();
    s4 = 2'b01; r4 = 4'h7; chk("ar_old", 0, 8'h05);
    step();
    re_n = 1'b1; chk("ar_new", 0, 8'h07);
    step();

    // Output enable, then async reset with a full stack
    s4 = 2'b00; oe_n4 = 1'b1; chk("oe_z", 0, 8'h0F);
    step();
    oe_n4 = 1'b0; chk("oe_upc", 0, 8'h09); fe_n = 1'b0; pup = 1'b1;
    step();
    step();
    step();
    step();
    fe_n = 1'b1; chk("pre_rst_full", 2, 8'h01); chk("pre_rst_y", 0, 8'h0D);
    step();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    chk("arst_y", 0, 8'h00); chk("arst_full", 2, 8'h00); chk("arst_empty", 3, 8'h01);
`ifdef AM29XX_STACK_ERR_EN
    chk("arst_err", 4, 8'h00);
`endif
    step();
    chk("post_rst", 0, 8'h01);
    step();

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
